// File: rtl/l1_ts_gen.sv
// ---------------------------------------------------------------------------
// l1_ts_gen
// Time-surface / trace generator for the first spiking layer.
//
// Four input event channels are rising-edge detected. Each detected edge
// emits a one-cycle pulse on o_event and loads that channel's time surface
// with all-ones. Four L1 neuron spike inputs are edge detected the same way
// and load per-neuron traces with all-ones. A prescaler produces a decay
// tick every p_decay_div clocks. On each tick every surface and trace
// decays toward zero and saturates there. i_freeze halts the prescaler and
// the decay, but loads still happen while it is set.
//
// Optional feature macro: TS_EXP_DECAY_EN
//   undefined : linear decay, step = 1
//   defined   : exponential-style decay, step = max(v >> p_exp_shift, 1)
//
// Parameters
//   p_width     : width of every surface / trace value
//   p_decay_div : clocks per decay tick (2..256)
//   p_exp_shift : decay shift (exponential mode only)
//
// Ports
//   i_clk         : clock, rising edge
//   i_rst_n       : asynchronous active-low reset
//   i_event       : [3:0] input event channel levels
//   i_l1_spikeout : [3:0] L1 neuron spike levels
//   i_freeze      : halts prescaler and decay while high
//   o_event       : [3:0] one-cycle pulse per detected event rising edge
//   o_ts          : 4 neuron slices x 4 channels x p_width, all slices equal
//   o_tr          : 4 traces x p_width
//   o_tick        : one-cycle decay tick pulse
// ---------------------------------------------------------------------------
module l1_ts_gen #(
    parameter int p_width     = 9,
    parameter int p_decay_div = 16,
    parameter int p_exp_shift = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [3:0]                 i_event,
    input  logic [3:0]                 i_l1_spikeout,
    input  logic                       i_freeze,
    output logic [3:0]                 o_event,
    output logic [4*(4*p_width)-1:0]   o_ts,
    output logic [4*p_width-1:0]       o_tr,
    output logic                       o_tick
);

    localparam int                c_pw   = (p_decay_div > 2) ? $clog2(p_decay_div) : 1;
    localparam logic [c_pw-1:0]   c_last = c_pw'(p_decay_div - 1);
    localparam logic [p_width-1:0] c_ones = {p_width{1'b1}};

    // Reject configurations the prescaler or the shift cannot represent.
    if ((p_decay_div < 2) || (p_decay_div > 256) || (p_exp_shift < 0) ||
        (p_exp_shift >= p_width)) begin : g_bad_params
        $error("l1_ts_gen: illegal parameter combination");
    end

    logic [3:0]         event_q, event_d;
    logic [3:0]         spike_q, spike_d;
    logic [3:0]         event_pls_q, event_pls_d;
    logic [p_width-1:0] ts_q [4];
    logic [p_width-1:0] ts_d [4];
    logic [p_width-1:0] tr_q [4];
    logic [p_width-1:0] tr_d [4];
    logic [c_pw-1:0]    presc_q, presc_d;
    logic               tick_q, tick_d;

    logic [3:0]         ev_rise;
    logic [3:0]         sp_rise;
    logic               decay;

    // One decay step toward zero; zero stays zero and never wraps.
    function automatic logic [p_width-1:0] f_decay(input logic [p_width-1:0] v);
        logic [p_width-1:0] step;
`ifdef TS_EXP_DECAY_EN
        step = v >> p_exp_shift;
        if (step == '0) begin
            step = p_width'(1);
        end
`else
        step = p_width'(1);
`endif
        if (v == '0) begin
            return '0;
        end
        return v - step;
    endfunction

    // Next-state logic for edge detectors, prescaler, surfaces and traces.
    always_comb begin
        event_d     = i_event;
        spike_d     = i_l1_spikeout;
        ev_rise     = i_event & ~event_q;
        sp_rise     = i_l1_spikeout & ~spike_q;
        event_pls_d = ev_rise;
        decay       = tick_q & ~i_freeze;

        // The prescaler only leaves its last value on a cycle that actually
        // carried a tick, so a freeze that lands on the last count delays
        // that tick instead of swallowing it.
        presc_d = presc_q;
        if (!i_freeze) begin
            if (presc_q == c_last) begin
                if (tick_q) begin
                    presc_d = '0;
                end
            end else begin
                presc_d = presc_q + c_pw'(1);
            end
        end
        tick_d = ~i_freeze & (presc_d == c_last);

        // A load beats a coincident decay.
        for (int k = 0; k < 4; k++) begin
            ts_d[k] = ts_q[k];
            tr_d[k] = tr_q[k];
            if (ev_rise[k]) begin
                ts_d[k] = c_ones;
            end else if (decay) begin
                ts_d[k] = f_decay(ts_q[k]);
            end
            if (sp_rise[k]) begin
                tr_d[k] = c_ones;
            end else if (decay) begin
                tr_d[k] = f_decay(tr_q[k]);
            end
        end
    end

    // State registers; reset clears everything immediately.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            event_q     <= '0;
            spike_q     <= '0;
            event_pls_q <= '0;
            presc_q     <= '0;
            tick_q      <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                ts_q[k] <= '0;
                tr_q[k] <= '0;
            end
        end else begin
            event_q     <= event_d;
            spike_q     <= spike_d;
            event_pls_q <= event_pls_d;
            presc_q     <= presc_d;
            tick_q      <= tick_d;
            for (int k = 0; k < 4; k++) begin
                ts_q[k] <= ts_d[k];
                tr_q[k] <= tr_d[k];
            end
        end
    end

    // Output packing: every neuron slice carries the same four channel
    // surfaces; all outputs come straight from flops.
    for (genvar n = 0; n < 4; n++) begin : g_pack_n
        for (genvar c = 0; c < 4; c++) begin : g_pack_c
            assign o_ts[p_width*(4*n+c) +: p_width] = ts_q[c];
        end
        assign o_tr[p_width*n +: p_width] = tr_q[n];
    end

    assign o_event = event_pls_q;
    assign o_tick  = tick_q;

endmodule
